maxpool_window_sequencer: RTL and testbench
===========================================

Name: maxpool_window_sequencer

Overview:
- Time-multiplexed 2x2/stride-2 max-pooling controller.
- Walks a D x H x W feature map held in a single-port, read-latency-1 input memory. Fetches the four words of each window and drives them into one shared external MaxUnit. Writes each result to an output memory.
- Replaces the fully parallel pooling array where area is constrained. Sits between the conv-layer feature buffer and the next layer's input buffer.

Parameters:
- DATA_BITS, 32, word width of feature values
- D, 1, number of channels
- W, 46, input width in words
- H, 46, input height in words
- ADDR_BITS, 16, width of both memory address buses; must cover D*H*W

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a pooling pass; sampled only in IDLE
- busy  output  1  high while a pass is in progress
- done  output  1  one-cycle pulse when the pass completes
- in_rd_en  output  1  input memory read strobe
- in_rd_addr  output  ADDR_BITS  input memory word address
- in_rd_data  input  DATA_BITS  read data, valid the cycle after in_rd_en
- max_a, max_b, max_c, max_d  output  DATA_BITS each  operands to the external MaxUnit (top-left, top-right, bottom-left, bottom-right)
- max_out  input  DATA_BITS  combinational result from the external MaxUnit
- out_wr_en  output  1  output memory write strobe
- out_wr_addr  output  ADDR_BITS  output memory word address
- out_wr_data  output  DATA_BITS  output memory write data

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - Channel, row and column counters clear to 0.
  - All outputs go to 0: busy, done, in_rd_en, in_rd_addr, max_a..max_d, out_wr_en, out_wr_addr, out_wr_data.
  - Reset mid-pass abandons the pass. No write is issued after reset asserts.
- Output geometry:
  - OH = H/2, OW = W/2 (floor).
  - If H or W is odd, the last row or column is ignored and never read.
- Addressing (c channel, r even row, k even column):
  - A = c*H*W + r*W + k
  - B = A + 1
  - C = A + W
  - D = A + W + 1
  - Output address = c*OH*OW + (r/2)*OW + k/2
  - Computed from counters, not multipliers, where practical. Must be exact modulo 2^ADDR_BITS.
- FSM states: IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE.
  - IDLE: busy=0. start=1 at a clock edge moves to RD0, counters at (0,0,0). start while busy is ignored.
  - RD0: in_rd_en=1, address A.
  - RD1: in_rd_en=1, address B; capture in_rd_data into max_a.
  - RD2: in_rd_en=1, address C; capture into max_b.
  - RD3: in_rd_en=1, address D; capture into max_c.
  - CAP: in_rd_en=0; capture into max_d.
  - WR: out_wr_en=1; out_wr_addr per formula; out_wr_data=max_out, combinational passthrough while max_a..max_d are stable.
    - Then advance k by 2.
    - At k+2 >= 2*OW: wrap k to 0 and advance r by 2.
    - At r wrap: advance c.
    - After the last window (c=D-1, r=2*OH-2, k=2*OW-2) go to DONE, else go to RD0.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy is high in RD0..WR inclusive.
- Strobes are registered outputs, asserted only in the states listed above.
- max_a..max_d hold their last values between windows and after the pass.
- Timing:
  - 6 cycles per window.
  - Pass length = 6*D*OH*OW cycles from the first RD0 to the last WR. done follows one cycle later.
  - start asserted in the DONE cycle is ignored. A new pass may start from IDLE on the next cycle.
- Degenerate case: OH=0 or OW=0 (H<2 or W<2). start goes directly to DONE, with no reads or writes.

Test Plan:
- Reset: hold reset_n=0 with random inputs, release mid-clock -> all outputs 0, state IDLE. Assert reset_n=0 asynchronously mid-RD2 of a pass -> outputs 0 immediately, no out_wr_en afterwards.
- Basic pass, W=H=4, D=1, input memory word i = i, signed-max MaxUnit model:
  - read addresses per window are 0,1,4,5 / 2,3,6,7 / 8,9,12,13 / 10,11,14,15
  - writes are addr0=5, addr1=7, addr2=13, addr3=15
  - done pulses exactly 25 cycles after the start edge
- Multichannel, W=H=4, D=2 -> channel 1 reads start at address 16; writes to addresses 4..7 with values 21,23,29,31; 48 busy cycles.
- Odd dims, W=5, H=3, D=1 -> OW=2, OH=1. Reads 0,1,5,6 then 2,3,7,8. Writes to addr 0 and 1 only. Row 2 and column 4 are never addressed.
- Handshake: start held high for the whole pass and through DONE -> exactly one pass, no re-trigger until the IDLE cycle. Back-to-back start in IDLE immediately after done -> second pass begins one cycle later.
- Operand ordering: plant window values A=-3, B=7, C=7, D=2 with a MaxUnit stub echoing max_b -> out_wr_data=7. Check max_a..max_d equal -3,7,7,2 during WR.

Source files
------------

// File: rtl/maxpool_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_window_sequencer
//  Purpose  : Time-multiplexed 2x2 / stride-2 max-pooling controller. Walks a
//             D x H x W feature map in a read-latency-1 memory, feeds the four
//             words of each window to a shared external MaxUnit and writes the
//             result to the output memory.
//  Revision : 1.0 - initial release
// ============================================================================
module maxpool_window_sequencer #(
   parameter int DATA_BITS = 32,
   parameter int D         = 1,
   parameter int W         = 46,
   parameter int H         = 46,
   parameter int ADDR_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 in_rd_en,
   output logic [ADDR_BITS-1:0] in_rd_addr,
   input  logic [DATA_BITS-1:0] in_rd_data,
   output logic [DATA_BITS-1:0] max_a,
   output logic [DATA_BITS-1:0] max_b,
   output logic [DATA_BITS-1:0] max_c,
   output logic [DATA_BITS-1:0] max_d,
   input  logic [DATA_BITS-1:0] max_out,
   output logic                 out_wr_en,
   output logic [ADDR_BITS-1:0] out_wr_addr,
   output logic [DATA_BITS-1:0] out_wr_data
);

   localparam int OH = H / 2;
   localparam int OW = W / 2;
   localparam bit DEGENERATE = (OH == 0) || (OW == 0);

   // Counter limits and address strides, truncated so all address arithmetic
   // wraps modulo 2^ADDR_BITS.
   localparam logic [ADDR_BITS-1:0] C_COL_LAST  = ADDR_BITS'(OW - 1);
   localparam logic [ADDR_BITS-1:0] C_ROW_LAST  = ADDR_BITS'(OH - 1);
   localparam logic [ADDR_BITS-1:0] C_CHAN_LAST = ADDR_BITS'(D - 1);
   localparam logic [ADDR_BITS-1:0] C_W         = ADDR_BITS'(W);
   localparam logic [ADDR_BITS-1:0] C_ROW_STEP  = ADDR_BITS'(2 * W);
   localparam logic [ADDR_BITS-1:0] C_CHAN_STEP = ADDR_BITS'(H * W);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_RD2  = 3'd3,
      S_RD3  = 3'd4,
      S_CAP  = 3'd5,
      S_WR   = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t               r_state;
   // Window indices: column = k/2, row = r/2, channel = c.
   logic [ADDR_BITS-1:0] r_col;
   logic [ADDR_BITS-1:0] r_row;
   logic [ADDR_BITS-1:0] r_chan;
   // Running bases: top-left of window, start of current row pair, channel.
   logic [ADDR_BITS-1:0] r_win_addr;
   logic [ADDR_BITS-1:0] r_row_addr;
   logic [ADDR_BITS-1:0] r_chan_addr;
   // Output addresses are dense, so a plain counter tracks them.
   logic [ADDR_BITS-1:0] r_out_idx;

   logic                 w_col_last;
   logic                 w_row_last;
   logic                 w_chan_last;
   logic [ADDR_BITS-1:0] w_next_col;
   logic [ADDR_BITS-1:0] w_next_row;
   logic [ADDR_BITS-1:0] w_next_chan;
   logic [ADDR_BITS-1:0] w_next_win;
   logic [ADDR_BITS-1:0] w_next_row_addr;
   logic [ADDR_BITS-1:0] w_next_chan_addr;

   // Next-window counters and base addresses, using adders only.
   always_comb begin
      w_col_last       = (r_col  == C_COL_LAST);
      w_row_last       = (r_row  == C_ROW_LAST);
      w_chan_last      = (r_chan == C_CHAN_LAST);
      w_next_col       = r_col + 1'b1;
      w_next_row       = r_row;
      w_next_chan      = r_chan;
      w_next_win       = r_win_addr + ADDR_BITS'(2);
      w_next_row_addr  = r_row_addr;
      w_next_chan_addr = r_chan_addr;
      if (w_col_last) begin
         w_next_col = '0;
         if (!w_row_last) begin
            w_next_row      = r_row + 1'b1;
            w_next_row_addr = r_row_addr + C_ROW_STEP;
         end else begin
            // Odd trailing rows/columns are skipped by jumping to the channel base.
            w_next_row       = '0;
            w_next_chan      = r_chan + 1'b1;
            w_next_chan_addr = r_chan_addr + C_CHAN_STEP;
            w_next_row_addr  = w_next_chan_addr;
         end
         w_next_win = w_next_row_addr;
      end
   end

   // Main sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_chan      <= '0;
         r_win_addr  <= '0;
         r_row_addr  <= '0;
         r_chan_addr <= '0;
         r_out_idx   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         in_rd_en    <= 1'b0;
         in_rd_addr  <= '0;
         max_a       <= '0;
         max_b       <= '0;
         max_c       <= '0;
         max_d       <= '0;
         out_wr_en   <= 1'b0;
         out_wr_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_col       <= '0;
                  r_row       <= '0;
                  r_chan      <= '0;
                  r_win_addr  <= '0;
                  r_row_addr  <= '0;
                  r_chan_addr <= '0;
                  r_out_idx   <= '0;
                  if (DEGENERATE) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state    <= S_RD0;
                     busy       <= 1'b1;
                     in_rd_en   <= 1'b1;
                     in_rd_addr <= '0;
                  end
               end
            end
            S_RD0: begin
               in_rd_addr <= r_win_addr + 1'b1;
               r_state    <= S_RD1;
            end
            S_RD1: begin
               max_a      <= in_rd_data;
               in_rd_addr <= r_win_addr + C_W;
               r_state    <= S_RD2;
            end
            S_RD2: begin
               max_b      <= in_rd_data;
               in_rd_addr <= r_win_addr + C_W + 1'b1;
               r_state    <= S_RD3;
            end
            S_RD3: begin
               max_c    <= in_rd_data;
               in_rd_en <= 1'b0;
               r_state  <= S_CAP;
            end
            S_CAP: begin
               max_d       <= in_rd_data;
               out_wr_en   <= 1'b1;
               out_wr_addr <= r_out_idx;
               r_state     <= S_WR;
            end
            S_WR: begin
               out_wr_en   <= 1'b0;
               r_out_idx   <= r_out_idx + 1'b1;
               r_col       <= w_next_col;
               r_row       <= w_next_row;
               r_chan      <= w_next_chan;
               r_win_addr  <= w_next_win;
               r_row_addr  <= w_next_row_addr;
               r_chan_addr <= w_next_chan_addr;
               if (w_col_last && w_row_last && w_chan_last) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_state    <= S_RD0;
                  in_rd_en   <= 1'b1;
                  in_rd_addr <= w_next_win;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // MaxUnit result passes straight through while the write strobe is high.
   assign out_wr_data = out_wr_en ? max_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maxpool_window_sequencer
//  Purpose  : Self-checking bench; four DUT geometries checked against a
//             window-by-window reference model of the pooling pass.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_window_sequencer;

   localparam int NDUT = 4;
   localparam int DB   = 32;
   localparam int AB   = 16;
   localparam int MEMN = 64;

   // Geometry per instance: 0 = 4x4x1, 1 = 4x4x2, 2 = W5 H3 D1, 3 = W1 H4 (degenerate)
   function automatic int cfg_d(input int g);
      return (g == 1) ? 2 : 1;
   endfunction
   function automatic int cfg_w(input int g);
      return (g == 2) ? 5 : ((g == 3) ? 1 : 4);
   endfunction
   function automatic int cfg_h(input int g);
      return (g == 2) ? 3 : 4;
   endfunction

   function automatic logic [DB-1:0] smax4(input logic [DB-1:0] a, b, c, d);
      logic signed [DB-1:0] v[4];
      logic signed [DB-1:0] m;
      v = '{a, b, c, d};
      m = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
      return m;
   endfunction

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start     [NDUT];
   logic          busy      [NDUT];
   logic          done      [NDUT];
   logic          in_rd_en  [NDUT];
   logic [AB-1:0] in_rd_addr[NDUT];
   logic [DB-1:0] in_rd_data[NDUT];
   logic [DB-1:0] max_a     [NDUT];
   logic [DB-1:0] max_b     [NDUT];
   logic [DB-1:0] max_c     [NDUT];
   logic [DB-1:0] max_d     [NDUT];
   logic [DB-1:0] max_out   [NDUT];
   logic          out_wr_en [NDUT];
   logic [AB-1:0] out_wr_addr[NDUT];
   logic [DB-1:0] out_wr_data[NDUT];

   logic [DB-1:0] mem   [NDUT][MEMN];
   logic          echo_b[NDUT];

   logic [AB-1:0]   rd_q[NDUT][$];
   logic [AB-1:0]   wa_q[NDUT][$];
   logic [DB-1:0]   wd_q[NDUT][$];
   logic [4*DB-1:0] op_q[NDUT][$];
   int              busy_cnt[NDUT];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      maxpool_window_sequencer #(
         .DATA_BITS(DB), .D(cfg_d(g)), .W(cfg_w(g)), .H(cfg_h(g)), .ADDR_BITS(AB)
      ) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .start      (start[g]),
         .busy       (busy[g]),
         .done       (done[g]),
         .in_rd_en   (in_rd_en[g]),
         .in_rd_addr (in_rd_addr[g]),
         .in_rd_data (in_rd_data[g]),
         .max_a      (max_a[g]),
         .max_b      (max_b[g]),
         .max_c      (max_c[g]),
         .max_d      (max_d[g]),
         .max_out    (max_out[g]),
         .out_wr_en  (out_wr_en[g]),
         .out_wr_addr(out_wr_addr[g]),
         .out_wr_data(out_wr_data[g])
      );
   end

   // Read-latency-1 input memories.
   always @(posedge clk)
      for (int g = 0; g < NDUT; g++) in_rd_data[g] <= mem[g][in_rd_addr[g][5:0]];

   // External MaxUnit: signed max, or an echo of operand b.
   always_comb
      for (int g = 0; g < NDUT; g++)
         max_out[g] = echo_b[g] ? max_b[g] : smax4(max_a[g], max_b[g], max_c[g], max_d[g]);

   // Bus monitor, sampled on the falling edge.
   always @(negedge clk)
      for (int g = 0; g < NDUT; g++) begin
         if (in_rd_en[g]) rd_q[g].push_back(in_rd_addr[g]);
         if (out_wr_en[g]) begin
            wa_q[g].push_back(out_wr_addr[g]);
            wd_q[g].push_back(out_wr_data[g]);
            op_q[g].push_back({max_a[g], max_b[g], max_c[g], max_d[g]});
         end
         if (busy[g]) busy_cnt[g]++;
      end

   task automatic clear_mon(input int g);
      rd_q[g].delete();
      wa_q[g].delete();
      wd_q[g].delete();
      op_q[g].delete();
      busy_cnt[g] = 0;
   endtask

   task automatic fill_index(input int g);
      for (int i = 0; i < MEMN; i++) mem[g][i] = DB'(i);
   endtask

   task automatic fill_random(input int g);
      for (int i = 0; i < MEMN; i++) mem[g][i] = $urandom;
   endtask

   function automatic bit all_zero(input int g);
      return !(busy[g] | done[g] | in_rd_en[g] | out_wr_en[g] | (|in_rd_addr[g]) |
               (|out_wr_addr[g]) | (|out_wr_data[g]) | (|max_a[g]) | (|max_b[g]) |
               (|max_c[g]) | (|max_d[g]));
   endfunction

   // Compares the recorded bus traffic with the expected pass, window by window.
   task automatic compare_with_model(input int g);
      int dd, hh, ww, oh, ow, n, base;
      int addr[4];
      logic [DB-1:0] exp_d;
      dd = cfg_d(g); hh = cfg_h(g); ww = cfg_w(g); oh = hh / 2; ow = ww / 2;
      checks++;
      if (rd_q[g].size() != 4 * dd * oh * ow || wa_q[g].size() != dd * oh * ow) begin
         errors++;
         $display("FAIL model_counts[%0d]: reads/writes %0d/%0d, required %0d/%0d", g,
                  rd_q[g].size(), wa_q[g].size(), 4 * dd * oh * ow, dd * oh * ow);
      end
      n = 0;
      for (int c = 0; c < dd; c++)
         for (int r = 0; r < oh; r++)
            for (int k = 0; k < ow; k++) begin
               base = c * hh * ww + 2 * r * ww + 2 * k;
               addr = '{base, base + 1, base + ww, base + ww + 1};
               for (int j = 0; j < 4; j++)
                  if (4 * n + j < rd_q[g].size()) begin
                     checks++;
                     if (rd_q[g][4 * n + j] !== AB'(addr[j])) begin
                        errors++;
                        $display("FAIL model_read[%0d] #%0d: got %0d, required %0d", g,
                                 4 * n + j, rd_q[g][4 * n + j], addr[j]);
                     end
                  end
               exp_d = echo_b[g] ? mem[g][addr[1]] :
                       smax4(mem[g][addr[0]], mem[g][addr[1]], mem[g][addr[2]], mem[g][addr[3]]);
               if (n < wa_q[g].size()) begin
                  checks++;
                  if (wa_q[g][n] !== AB'(c * oh * ow + r * ow + k) || wd_q[g][n] !== exp_d) begin
                     errors++;
                     $display("FAIL model_write[%0d] #%0d: got addr %0d data %0h, required addr %0d data %0h",
                              g, n, wa_q[g][n], wd_q[g][n], c * oh * ow + r * ow + k, exp_d);
                  end
               end
               n++;
            end
   endtask

   // Starts a pass and checks done latency, busy length and the done pulse width.
   task automatic run_pass(input int g, input bit hold);
      int windows, cyc;
      windows = cfg_d(g) * (cfg_h(g) / 2) * (cfg_w(g) / 2);
      clear_mon(g);
      @(negedge clk); start[g] = 1'b1;
      @(negedge clk); cyc = 1;
      if (!hold) start[g] = 1'b0;
      while (done[g] !== 1'b1 && cyc < 6 * windows + 20) begin
         @(negedge clk); cyc++;
      end
      checks++;
      if (done[g] !== 1'b1 || cyc != 6 * windows + 1) begin
         errors++;
         $display("FAIL done_latency[%0d]: done=%b at cycle %0d, required 1 at cycle %0d",
                  g, done[g], cyc, 6 * windows + 1);
      end
      checks++;
      if (busy_cnt[g] != 6 * windows) begin
         errors++;
         $display("FAIL busy_cycles[%0d]: got %0d, required %0d", g, busy_cnt[g], 6 * windows);
      end
      @(negedge clk);
      checks++;
      if (done[g] !== 1'b0 || busy[g] !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse[%0d]: done=%b busy=%b, required 0 0", g, done[g], busy[g]);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (4) begin
         @(negedge clk);
         for (int g = 0; g < NDUT; g++) start[g] = 1'($urandom);
      end
      for (int g = 0; g < NDUT; g++) begin
         checks++;
         if (!all_zero(g)) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: busy=%b addr=%0d wr=%b, required all 0",
                     g, busy[g], in_rd_addr[g], out_wr_en[g]);
         end
      end
      for (int g = 0; g < NDUT; g++) start[g] = 1'b0;
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         checks++;
         if (!all_zero(g)) begin
            errors++;
            $display("FAIL post_reset_idle[%0d]: busy=%b rd_en=%b, required 0 0", g, busy[g], in_rd_en[g]);
         end
      end
   endtask

   task automatic test_basic();
      int exp_w[4];
      exp_w = '{5, 7, 13, 15};
      fill_index(0);
      run_pass(0, 1'b0);
      compare_with_model(0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wd_q[0].size() || wd_q[0][i] !== DB'(exp_w[i]) || wa_q[0][i] !== AB'(i)) begin
            errors++;
            $display("FAIL basic_write #%0d: got addr/data %0d/%0d, required %0d/%0d", i,
                     (i < wa_q[0].size()) ? wa_q[0][i] : AB'(0),
                     (i < wd_q[0].size()) ? wd_q[0][i] : DB'(0), i, exp_w[i]);
         end
      end
      // Same geometry with random signed content.
      for (int rep = 0; rep < 2; rep++) begin
         fill_random(0);
         run_pass(0, 1'b0);
         compare_with_model(0);
      end
   endtask

   task automatic test_multichannel();
      int exp_w[4];
      exp_w = '{21, 23, 29, 31};
      fill_index(1);
      run_pass(1, 1'b0);
      compare_with_model(1);
      checks++;
      if (rd_q[1].size() < 17 || rd_q[1][16] !== AB'(16)) begin
         errors++;
         $display("FAIL chan1_first_read: got %0d, required 16",
                  (rd_q[1].size() > 16) ? rd_q[1][16] : AB'(0));
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wd_q[1].size() < 8 || wa_q[1][4 + i] !== AB'(4 + i) || wd_q[1][4 + i] !== DB'(exp_w[i])) begin
            errors++;
            $display("FAIL chan1_write #%0d: required addr %0d data %0d", i, 4 + i, exp_w[i]);
         end
      end
      fill_random(1);
      run_pass(1, 1'b0);
      compare_with_model(1);
   endtask

   task automatic test_odd_dims();
      int exp_r[8];
      int bad;
      exp_r = '{0, 1, 5, 6, 2, 3, 7, 8};
      fill_index(2);
      run_pass(2, 1'b0);
      compare_with_model(2);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= rd_q[2].size() || rd_q[2][i] !== AB'(exp_r[i])) begin
            errors++;
            $display("FAIL odd_read #%0d: required %0d", i, exp_r[i]);
         end
      end
      bad = 0;
      foreach (rd_q[2][i]) if (int'(rd_q[2][i]) % 5 == 4 || int'(rd_q[2][i]) / 5 >= 2) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL odd_ignored_edges: %0d reads in row 2 or column 4, required 0", bad);
      end
   endtask

   task automatic test_degenerate();
      run_pass(3, 1'b0);
      checks++;
      if (rd_q[3].size() != 0 || wa_q[3].size() != 0) begin
         errors++;
         $display("FAIL degenerate_traffic: reads %0d writes %0d, required 0 0",
                  rd_q[3].size(), wa_q[3].size());
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      fill_random(0);
      run_pass(0, 1'b1);   // start stays high through DONE; now in the IDLE cycle
      checks++;
      if (rd_q[0].size() != 16 || wa_q[0].size() != 4) begin
         errors++;
         $display("FAIL held_start_single_pass: reads %0d writes %0d, required 16 4",
                  rd_q[0].size(), wa_q[0].size());
      end
      clear_mon(0);
      @(negedge clk);
      start[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b1 || in_rd_en[0] !== 1'b1 || in_rd_addr[0] !== AB'(0)) begin
         errors++;
         $display("FAIL back_to_back_start: busy=%b rd_en=%b addr=%0d, required 1 1 0",
                  busy[0], in_rd_en[0], in_rd_addr[0]);
      end
      cyc = 1;
      while (done[0] !== 1'b1 && cyc < 60) begin
         @(negedge clk); cyc++;
      end
      checks++;
      if (cyc != 25) begin
         errors++;
         $display("FAIL back_to_back_done: at cycle %0d, required 25", cyc);
      end
      compare_with_model(0);
      @(negedge clk);
   endtask

   task automatic test_operand_order();
      fill_random(0);
      mem[0][0] = 32'hFFFF_FFFD;
      mem[0][1] = 32'd7;
      mem[0][4] = 32'd7;
      mem[0][5] = 32'd2;
      echo_b[0] = 1'b1;
      run_pass(0, 1'b0);
      compare_with_model(0);
      checks++;
      if (op_q[0].size() == 0 || op_q[0][0] !== {32'hFFFF_FFFD, 32'd7, 32'd7, 32'd2} ||
          wd_q[0][0] !== 32'd7) begin
         errors++;
         $display("FAIL operand_order: got ops %h data %0d, required fffffffd/7/7/2 data 7",
                  (op_q[0].size() > 0) ? op_q[0][0] : '0, (wd_q[0].size() > 0) ? wd_q[0][0] : '0);
      end
      echo_b[0] = 1'b0;
   endtask

   task automatic test_reset_mid_pass();
      for (int i = 0; i < MEMN; i++) mem[0][i] = DB'(i + 1);
      clear_mon(0);
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;   // RD0
      @(negedge clk);                    // RD1
      @(negedge clk);                    // RD2
      checks++;
      if (in_rd_en[0] !== 1'b1 || in_rd_addr[0] !== AB'(4) || max_a[0] !== DB'(1)) begin
         errors++;
         $display("FAIL rd2_state: rd_en=%b addr=%0d max_a=%0d, required 1 4 1",
                  in_rd_en[0], in_rd_addr[0], max_a[0]);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (!all_zero(0)) begin
         errors++;
         $display("FAIL async_reset: busy=%b rd_en=%b addr=%0d max_a=%0d, required all 0",
                  busy[0], in_rd_en[0], in_rd_addr[0], max_a[0]);
      end
      clear_mon(0);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (wa_q[0].size() != 0 || rd_q[0].size() != 0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL post_abort_traffic: writes %0d reads %0d busy %b, required 0 0 0",
                  wa_q[0].size(), rd_q[0].size(), busy[0]);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      for (int g = 0; g < NDUT; g++) begin
         start[g]  = 1'b0;
         echo_b[g] = 1'b0;
         fill_index(g);
         clear_mon(g);
      end
      test_reset();
      test_basic();
      test_multichannel();
      test_odd_dims();
      test_degenerate();
      test_back_to_back();
      test_operand_order();
      test_reset_mid_pass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
